axi_core_mem_slave: RTL and testbench
=====================================

Name: axi_core_mem_slave

Overview:
- AXI4 slave responder for the accelerator's core memory master port (aw/w/b/ar/r subset: addr, len, data, strb, last, resp; INCR bursts of full-width beats only).
- Backed by an internal word-addressed memory array.
- Used as the DRAM stand-in for block-level and top-level simulation, and as an on-chip scratch memory option.
- Read and write channels run as independent state machines and may be active concurrently.

Parameters:
ADDR_WIDTH, 32, byte address width of aw/ar addresses
DATA_WIDTH, 128, beat width in bits; power of two, at least 32
MEM_DEPTH, 1024, number of DATA_WIDTH words in the array; power of two
BASE_ADDR, 0, byte address mapped to word 0

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
s_axi_awready  out  1  write address ready
s_axi_awvalid  in  1  write address valid
s_axi_awaddr  in  ADDR_WIDTH  write burst start byte address
s_axi_awlen  in  8  write beats minus 1
s_axi_wready  out  1  write data ready
s_axi_wvalid  in  1  write data valid
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_bready  in  1  response ready
s_axi_bvalid  out  1  response valid
s_axi_bresp  out  2  write response
s_axi_arready  out  1  read address ready
s_axi_arvalid  in  1  read address valid
s_axi_araddr  in  ADDR_WIDTH  read burst start byte address
s_axi_arlen  in  8  read beats minus 1
s_axi_rready  in  1  read data ready
s_axi_rvalid  out  1  read data valid
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat

Behaviour:
- Reset: every ready and valid output 0; bresp, rresp, rdata and rlast 0. Both state machines go to IDLE, including mid-burst; any burst in flight is abandoned. Memory contents are not cleared.
- Reset release: awready and arready rise 1 cycle after rst deasserts.
- Word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). The low address bits are ignored, so unaligned addresses are truncated. The index increments by 1 per beat.
- A beat is out of range if its byte address < BASE_ADDR or its word index >= MEM_DEPTH. This is checked per beat, so a burst that runs off the end errors only for the excess beats.
- Write FSM, W_IDLE:
  - awready=1. On aw handshake, latch the address and awlen, then go to W_DATA.
- Write FSM, W_DATA:
  - wready=1 and awready=0.
  - Each w handshake writes the bytes where wstrb[i]=1; bytes with wstrb[i]=0 are unchanged.
  - Out-of-range beats are dropped and set a sticky error flag.
  - The beat counter alone ends the burst: after awlen+1 beats, go to W_RESP.
  - If wlast disagrees with the counter on any beat, set the error flag. The burst length is still taken from the counter.
- Write FSM, W_RESP:
  - bvalid=1, bresp=2'b10 if the error flag is set, otherwise 2'b00.
  - Hold bvalid until bready, then return to W_IDLE and clear the error flag.
- Read FSM, R_IDLE:
  - arready=1. On ar handshake, go to R_DATA. The first rvalid comes exactly 1 cycle after the handshake (registered array read).
- Read FSM, R_DATA:
  - Each beat: rvalid=1; rdata = memory word, or 0 if out of range; rresp = 2'b00, or 2'b10 if out of range; rlast=1 on beat arlen.
  - With rvalid=1 and rready=0, rdata, rresp and rlast hold stable.
  - On an r handshake the next beat is presented the following cycle, giving full throughput of 1 beat/cycle.
  - After the handshake of the last beat, go to R_IDLE. arready is reasserted the next cycle, so there is at least 1 idle cycle between read bursts.
- Collision: a read and a write to the same word in the same cycle return the old data (read-before-write). The write is visible to the next read of that word.
- awlen=0 and arlen=0 are single-beat bursts. awlen=255 and arlen=255 are 256 beats. No 4 KB boundary check.
- No outstanding transactions: one write and one read at a time.

Test Plan:
- Single write, then read: aw addr 0x40, len 0, wdata 0xA5 pattern, full strb, then ar 0x40 len 0 -> bresp 00; rdata equals the written pattern, rlast=1, rresp 00, rvalid 1 cycle after ar handshake.
- 16-beat write and read with rready toggling 1/0 each cycle -> 16 beats in order, rlast only on beat 15, rdata stable while stalled, no beat lost or duplicated.
- Partial strobe: word initially 0, write wstrb 0x000F with all-ones data -> read returns 0xFFFF_FFFF in the low 32 bits and 0 elsewhere.
- Range/protocol errors:
  - Write len 3 starting at the last word -> beat 0 stored, bresp 10.
  - Read at BASE_ADDR-16 -> rresp 10, rdata 0.
  - wlast asserted on beat 1 of a len-3 burst -> 4 beats accepted, bresp 10.
- Concurrency: write burst (len 7) and read burst (len 7) to the same addresses issued in the same cycle -> both complete; colliding beats return old data; a subsequent read returns the new data.
- rst pulsed mid read burst (beat 3 of 8) and mid write burst -> next cycle all valids 0; after release awready=arready=1; a new read returns previously written contents.

Source files
------------

// File: rtl/axi_core_mem_slave.sv
// AXI4 slave backed by a word-addressed memory array.
// Independent read and write burst engines share the array.
module axi_core_mem_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 128,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    s_axi_awready,
  input  logic                    s_axi_awvalid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  output logic                    s_axi_wready,
  input  logic                    s_axi_wvalid,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_bready,
  output logic                    s_axi_bvalid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_arready,
  input  logic                    s_axi_arvalid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic                    s_axi_rready,
  output logic                    s_axi_rvalid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int MAW    = $clog2(MEM_DEPTH);

  typedef logic [ADDR_WIDTH:0] idx_t;

  localparam idx_t DEPTH_L = idx_t'(MEM_DEPTH);

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  // One extra bit keeps addresses below BASE_ADDR negative.
  function automatic idx_t word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic signed [ADDR_WIDTH:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, BASE_ADDR});
    return idx_t'(d >>> OFFS);
  endfunction

  function automatic logic out_of_range(input idx_t i);
    return i >= DEPTH_L;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  w_state_e    w_state_q;
  idx_t        w_idx_q;
  logic [7:0]  w_len_q;
  logic [7:0]  w_cnt_q;
  logic        w_err_q;
  logic        w_err_d;
  logic        awready_q;
  logic        wready_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        w_hs;
  logic        w_oor;
  logic        w_last_beat;
  logic        mem_we;

  assign w_hs        = s_axi_wvalid && wready_q;
  assign w_oor       = out_of_range(w_idx_q);
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_err_d     = w_err_q || w_oor ||
                       (s_axi_wlast != w_last_beat);
  assign mem_we      = w_hs && !w_oor && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (awready_q && s_axi_awvalid) begin
            w_idx_q   <= word_idx(s_axi_awaddr);
            w_len_q   <= s_axi_awlen;
            w_cnt_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_err_q <= w_err_d;
            w_idx_q <= w_idx_q + idx_t'(1);
            w_cnt_q <= w_cnt_q + 8'd1;
            // Burst length comes from the counter, not wlast.
            if (w_last_beat) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= w_err_d ? 2'b10 : 2'b00;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            w_err_q   <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s_axi_wstrb[i]) begin
          mem_q[w_idx_q[MAW-1:0]][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
        end
      end
    end
  end

  r_state_e              r_state_q;
  idx_t                  r_idx_q;
  idx_t                  r_idx_d;
  logic [7:0]            r_len_q;
  logic [7:0]            r_len_d;
  logic [7:0]            r_cnt_q;
  logic [7:0]            r_cnt_d;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;
  logic                  r_oor;
  logic                  r_load;
  logic [DATA_WIDTH-1:0] r_word;

  // Index, length and beat number of the beat fetched this cycle.
  always_comb begin
    r_idx_d = r_idx_q;
    r_len_d = r_len_q;
    r_cnt_d = r_cnt_q + 8'd1;
    if (r_state_q == R_IDLE) begin
      r_idx_d = word_idx(s_axi_araddr);
      r_len_d = s_axi_arlen;
      r_cnt_d = '0;
    end
  end

  assign r_oor  = out_of_range(r_idx_d);
  assign r_word = r_oor ? '0 : mem_q[r_idx_d[MAW-1:0]];
  assign r_load = (r_state_q == R_IDLE) ?
                  (arready_q && s_axi_arvalid) :
                  (rvalid_q && s_axi_rready && !rlast_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      rlast_q   <= 1'b0;
    end else begin
      if (r_load) begin
        arready_q <= 1'b0;
        r_idx_q   <= r_idx_d + idx_t'(1);
        r_len_q   <= r_len_d;
        r_cnt_q   <= r_cnt_d;
        rvalid_q  <= 1'b1;
        rdata_q   <= r_word;
        rresp_q   <= r_oor ? 2'b10 : 2'b00;
        rlast_q   <= (r_cnt_d == r_len_d);
        r_state_q <= R_DATA;
      end else if (r_state_q == R_IDLE) begin
        arready_q <= 1'b1;
      end else if (rvalid_q && s_axi_rready) begin
        rvalid_q  <= 1'b0;
        rlast_q   <= 1'b0;
        arready_q <= 1'b1;
        r_state_q <= R_IDLE;
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_core_mem_slave.sv
// Directed bench for axi_core_mem_slave: vector table
// plus burst, error, concurrency and reset sequences.
module tb_axi_core_mem_slave;

  localparam logic [31:0]  BASE = 32'h1000;
  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] ALT  =
    128'h0123456789ABCDEF_FEDCBA9876543210;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         awready, awvalid = 1'b0;
  logic [31:0]  awaddr = '0;
  logic [7:0]   awlen = '0;
  logic         wready, wvalid = 1'b0;
  logic [127:0] wdata = '0;
  logic [15:0]  wstrb = '0;
  logic         wlast = 1'b0;
  logic         bready = 1'b0;
  logic         bvalid;
  logic [1:0]   bresp;
  logic         arready, arvalid = 1'b0;
  logic [31:0]  araddr = '0;
  logic [7:0]   arlen = '0;
  logic         rready = 1'b0;
  logic         rvalid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] rd_data [256];
  logic [1:0]   rd_resp [256];
  logic         rd_last [256];
  int           rd_n;

  always #5 clk = ~clk;

  axi_core_mem_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(128),
    .MEM_DEPTH (64),
    .BASE_ADDR (BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axi_awready(awready),
    .s_axi_awvalid(awvalid),
    .s_axi_awaddr (awaddr),
    .s_axi_awlen  (awlen),
    .s_axi_wready (wready),
    .s_axi_wvalid (wvalid),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wlast  (wlast),
    .s_axi_bready (bready),
    .s_axi_bvalid (bvalid),
    .s_axi_bresp  (bresp),
    .s_axi_arready(arready),
    .s_axi_arvalid(arvalid),
    .s_axi_araddr (araddr),
    .s_axi_arlen  (arlen),
    .s_axi_rready (rready),
    .s_axi_rvalid (rvalid),
    .s_axi_rdata  (rdata),
    .s_axi_rresp  (rresp),
    .s_axi_rlast  (rlast)
  );

  task automatic check(input string name,
                       input logic [159:0] act,
                       input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  function automatic logic [127:0] beat(input logic [127:0] b,
                                        input int i);
    return b + 128'(i);
  endfunction

  task automatic wr_burst(input logic [31:0] addr,
                          input logic [7:0] len,
                          input logic [127:0] d0,
                          input logic [15:0] strb,
                          input int badlast,
                          output logic [1:0] br);
    int t;
    awvalid = 1'b1;
    awaddr  = addr;
    awlen   = len;
    t = 0;
    while (!awready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) tmo("awready");
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1;
      wdata  = beat(d0, i);
      wstrb  = strb;
      wlast  = (badlast >= 0) ? (i == badlast)
                              : (i == int'(len));
      t = 0;
      while (!wready && t < 100) begin
        @(posedge clk); #1; t++;
      end
      if (t >= 100) tmo("wready");
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) tmo("bvalid");
    br = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic rd_burst(input logic [31:0] addr,
                          input logic [7:0] len,
                          input bit toggle);
    int t;
    int cyc;
    bit stalled;
    logic [130:0] held;
    arvalid = 1'b1;
    araddr  = addr;
    arlen   = len;
    t = 0;
    while (!arready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) tmo("arready");
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rvalid_lat", 160'(rvalid), 160'(1));
    rd_n    = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while (rd_n <= int'(len) && cyc < 1000) begin
      rready = toggle ? ~cyc[0] : 1'b1;
      if (stalled)
        check("r_stable", 160'({rdata, rresp, rlast}),
              160'(held));
      stalled = rvalid && !rready;
      held    = {rdata, rresp, rlast};
      if (rvalid && rready) begin
        rd_data[rd_n] = rdata;
        rd_resp[rd_n] = rresp;
        rd_last[rd_n] = rlast;
        rd_n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rready = 1'b0;
    if (cyc >= 1000) tmo("rbeats");
    check("r_end", 160'(rvalid), 160'(0));
  endtask

  task automatic chk_beats(input string name,
                           input logic [127:0] d0,
                           input int n);
    check({name, "_cnt"}, 160'(rd_n), 160'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_d%0d", name, i),
            160'(rd_data[i]), 160'(beat(d0, i)));
      check($sformatf("%s_l%0d", name, i),
            160'({rd_resp[i], rd_last[i]}),
            160'({2'b00, i == n - 1}));
    end
  endtask

  typedef struct {
    logic [31:0]  waddr;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic [31:0]  raddr;
    logic [1:0]   eb;
    logic [127:0] er;
    logic [1:0]   err;
  } vec_t;

  vec_t vt [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] br;
    logic [1:0] br2;

    vt[0] = '{32'h1040, A5,   16'hFFFF, 32'h1040,
              2'b00, A5, 2'b00};
    vt[1] = '{32'h1080, '0,   16'hFFFF, 32'h1080,
              2'b00, '0, 2'b00};
    vt[2] = '{32'h1080, ONES, 16'h000F, 32'h1080,
              2'b00, 128'hFFFF_FFFF, 2'b00};
    vt[3] = '{32'h1040, ONES, 16'h0000, 32'h1040,
              2'b00, A5, 2'b00};
    vt[4] = '{32'h10C7, ALT,  16'hFFFF, 32'h10C0,
              2'b00, ALT, 2'b00};
    vt[5] = '{32'h0FF0, ONES, 16'hFFFF, 32'h0FF0,
              2'b10, '0, 2'b10};
    vt[6] = '{32'h1400, ONES, 16'hFFFF, 32'h1400,
              2'b10, '0, 2'b10};
    vt[7] = '{32'h13F0, ALT,  16'hFFFF, 32'h13FF,
              2'b00, ALT, 2'b00};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out",
          160'({awready, wready, bvalid, bresp,
                arready, rvalid, rresp, rlast}), 160'(0));
    check("rst_rdata", 160'(rdata), 160'(0));
    rst = 1'b0;
    check("ready_at_rel", 160'({awready, arready}), 160'(0));
    @(posedge clk); #1;
    check("ready_after", 160'({awready, arready}), 160'(3));

    for (int k = 0; k < 8; k++) begin
      wr_burst(vt[k].waddr, 8'd0, vt[k].wdata,
               vt[k].wstrb, -1, br);
      check($sformatf("v%0d_bresp", k), 160'(br),
            160'(vt[k].eb));
      rd_burst(vt[k].raddr, 8'd0, 1'b0);
      check($sformatf("v%0d_rdata", k), 160'(rd_data[0]),
            160'(vt[k].er));
      check($sformatf("v%0d_rresp", k),
            160'({rd_resp[0], rd_last[0]}),
            160'({vt[k].err, 1'b1}));
    end

    // 16 beats, read back with rready toggling
    wr_burst(32'h1100, 8'd15, 128'hDA00, 16'hFFFF, -1, br);
    check("b16_bresp", 160'(br), 160'(0));
    rd_burst(32'h1100, 8'd15, 1'b1);
    chk_beats("b16", 128'hDA00, 16);

    // burst running off the end of the array
    wr_burst(32'h1000, 8'd0, 128'hC0DE, 16'hFFFF, -1, br);
    wr_burst(32'h13F0, 8'd3, 128'hBB00, 16'hFFFF, -1, br);
    check("end_bresp", 160'(br), 160'(2));
    rd_burst(32'h13F0, 8'd0, 1'b0);
    check("end_beat0", 160'(rd_data[0]), 160'(128'hBB00));
    rd_burst(32'h1000, 8'd0, 1'b0);
    check("end_nowrap", 160'(rd_data[0]), 160'(128'hC0DE));

    // early wlast: counter still decides the length
    wr_burst(32'h1180, 8'd3, 128'hCC00, 16'hFFFF, 1, br);
    check("wlast_bresp", 160'(br), 160'(2));
    rd_burst(32'h1180, 8'd3, 1'b0);
    chk_beats("wlast", 128'hCC00, 4);
    wr_burst(32'h11C0, 8'd0, 128'hCC80, 16'hFFFF, -1, br);
    check("err_clear", 160'(br), 160'(0));

    // concurrent write and read to the same words
    wr_burst(32'h1200, 8'd7, 128'hD000, 16'hFFFF, -1, br);
    fork
      wr_burst(32'h1200, 8'd7, 128'hD100, 16'hFFFF, -1, br);
      rd_burst(32'h1200, 8'd7, 1'b0);
    join
    check("cc0_bresp", 160'(br), 160'(0));
    chk_beats("cc0", 128'hD000, 8);
    fork
      wr_burst(32'h1200, 8'd7, 128'hD200, 16'hFFFF, -1, br2);
      begin
        @(posedge clk); #1;
        rd_burst(32'h1200, 8'd7, 1'b0);
      end
    join
    check("cc1_bresp", 160'(br2), 160'(0));
    chk_beats("cc1", 128'hD100, 8);
    rd_burst(32'h1200, 8'd7, 1'b0);
    chk_beats("cc2", 128'hD200, 8);

    // reset in the middle of both bursts
    awvalid = 1'b1; awaddr = 32'h1300; awlen = 8'd7;
    arvalid = 1'b1; araddr = 32'h1100; arlen = 8'd7;
    @(posedge clk); #1;
    awvalid = 1'b0;
    arvalid = 1'b0;
    wvalid  = 1'b1;
    wdata   = 128'hEE;
    wstrb   = 16'hFFFF;
    rready  = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_beat3", 160'({rvalid, rdata}),
          160'({1'b1, beat(128'hDA00, 3)}));
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out",
          160'({awready, wready, bvalid, arready,
                rvalid, rlast}), 160'(0));
    check("mid_rst_rdata", 160'(rdata), 160'(0));
    rst    = 1'b0;
    wvalid = 1'b0;
    rready = 1'b0;
    @(posedge clk); #1;
    check("mid_rel_ready", 160'({awready, arready}),
          160'(3));
    rd_burst(32'h1100, 8'd0, 1'b0);
    check("mid_keep", 160'(rd_data[0]), 160'(128'hDA00));
    wr_burst(32'h1300, 8'd0, 128'hEF, 16'hFFFF, -1, br);
    check("mid_wr_bresp", 160'(br), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
